// File: rtl/tff_toggle_arbiter.sv
// -----------------------------------------------------------------------------
// tff_toggle_arbiter
//
// Purpose:
//   A bank of NBITS toggle (T) flip-flops shared by NREQ requesters. Each
//   requester raises req[i] and supplies the index of the bit it wants toggled
//   on sel[i*SELW +: SELW]. A two-state FSM (IDLE/GRANT) picks one requester
//   round-robin, acknowledges it with a single-cycle grant pulse, and toggles
//   the chosen bit on the way back to IDLE. At most one toggle completes every
//   two cycles.
//
// Ports:
//   clk      in   1            rising-edge clock
//   rst      in   1            synchronous active-high reset
//   req      in   NREQ         per-requester toggle request (level, held)
//   sel      in   NREQ*SELW    per-requester target bit index
//   freeze   in   1            blocks new grants while high (IDLE only)
//   grant    out  NREQ         one-hot registered acknowledge pulse
//   q        out  NBITS        toggle-bit bank state (registered)
//   qbar     out  NBITS        bitwise inverse of q
//   busy     out  1            high while the FSM is in GRANT
//   tog_cnt  out  8            completed toggles, saturating at 255
// -----------------------------------------------------------------------------
module tff_toggle_arbiter #(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int SELW  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*SELW-1:0]   sel,
    input  logic                   freeze,
    output logic [NREQ-1:0]        grant,
    output logic [NBITS-1:0]       q,
    output logic [NBITS-1:0]       qbar,
    output logic                   busy,
    output logic [7:0]             tog_cnt
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Last winner resets to the highest index so requester 0 is searched first.
    localparam logic [IDXW-1:0] LAST_RST = IDXW'(NREQ - 1);

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Round-robin search starting just after the previous winner.
    // Returns {found, index}.
    function automatic logic [IDXW:0] rr_pick(
        input logic [NREQ-1:0] r,
        input logic [IDXW-1:0] last
    );
        logic            found;
        logic [IDXW-1:0] idx;
        logic [IDXW-1:0] cand;
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDXW'((int'(last) + k) % NREQ);
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    // Saturating increment for the toggle counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Single-bit mask selecting the bit to invert.
    function automatic logic [NBITS-1:0] bit_mask(input logic [SELW-1:0] s);
        return NBITS'(1) << s;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [0:0]       state_q,       state_d;
    logic [NREQ-1:0]  grant_q,       grant_d;
    logic [NBITS-1:0] q_q,           q_d;
    logic [7:0]       tog_cnt_q,     tog_cnt_d;
    logic [IDXW-1:0]  last_winner_q, last_winner_d;
    logic [IDXW-1:0]  win_idx_q,     win_idx_d;
    logic [SELW-1:0]  win_sel_q,     win_sel_d;

    // -------------------------------------------------------------------------
    // Arbitration (combinational, only consumed in IDLE)
    // -------------------------------------------------------------------------
    logic            rr_found;
    logic [IDXW-1:0] rr_idx;
    logic [SELW-1:0] rr_sel;

    always_comb begin
        {rr_found, rr_idx} = rr_pick(req, last_winner_q);
        rr_sel             = sel[int'(rr_idx)*SELW +: SELW];
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        grant_d       = '0;            // grant is a one-cycle pulse
        q_d           = q_q;
        tog_cnt_d     = tog_cnt_q;
        last_winner_d = last_winner_q;
        win_idx_d     = win_idx_q;
        win_sel_d     = win_sel_q;

        case (state_q)
            ST_IDLE: begin
                if (!freeze && rr_found) begin
                    state_d          = ST_GRANT;
                    grant_d[rr_idx]  = 1'b1;
                    win_idx_d        = rr_idx;
                    // sel is captured here; later changes cannot affect this toggle.
                    win_sel_d        = rr_sel;
                end
            end
            ST_GRANT: begin
                // freeze is deliberately ignored here: a started grant always completes.
                state_d       = ST_IDLE;
                q_d           = q_q ^ bit_mask(win_sel_q);
                tog_cnt_d     = sat_inc8(tog_cnt_q);
                last_winner_d = win_idx_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            q_q           <= '0;
            tog_cnt_q     <= '0;
            last_winner_q <= LAST_RST;
            win_idx_q     <= '0;
            win_sel_q     <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            q_q           <= q_d;
            tog_cnt_q     <= tog_cnt_d;
            last_winner_q <= last_winner_d;
            win_idx_q     <= win_idx_d;
            win_sel_q     <= win_sel_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign grant   = grant_q;
    assign q       = q_q;
    assign qbar    = ~q_q;
    assign busy    = (state_q == ST_GRANT);
    assign tog_cnt = tog_cnt_q;

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tff_toggle_arbiter
//
// Directed bench for tff_toggle_arbiter with default parameters
// (NREQ=4, NBITS=8, SELW=3). Inputs change 1 ns after a rising edge and
// outputs are sampled at the same point, so each observation reflects the
// registers loaded on the edge just taken.
// -----------------------------------------------------------------------------
module tb_tff_toggle_arbiter;

    localparam int NREQ  = 4;
    localparam int NBITS = 8;
    localparam int SELW  = 3;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*SELW-1:0] sel;
    logic                 freeze;
    logic [NREQ-1:0]      grant;
    logic [NBITS-1:0]     q;
    logic [NBITS-1:0]     qbar;
    logic                 busy;
    logic [7:0]           tog_cnt;

    int checks = 0;
    int errors = 0;

    tff_toggle_arbiter #(
        .NREQ  (NREQ),
        .NBITS (NBITS),
        .SELW  (SELW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .sel     (sel),
        .freeze  (freeze),
        .grant   (grant),
        .q       (q),
        .qbar    (qbar),
        .busy    (busy),
        .tog_cnt (tog_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input int i, input logic [SELW-1:0] v);
        sel[i*SELW +: SELW] = v;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        req    = '0;
        freeze = 1'b0;
        tick();
        tick();
        rst    = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_q;
        logic [2:0] s;

        rst    = 1'b1;
        req    = '0;
        sel    = '0;
        freeze = 1'b0;

        // ---------------- reset state and single toggle ----------------
        do_reset();
        check("rst_q",       32'(q),       32'h00);
        check("rst_qbar",    32'(qbar),    32'hFF);
        check("rst_grant",   32'(grant),   32'h0);
        check("rst_busy",    32'(busy),    32'h0);
        check("rst_tog_cnt", 32'(tog_cnt), 32'h0);

        req = 4'b0001;
        set_sel(0, 3'd3);
        tick();                                   // cycle 1
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_busy",  32'(busy),  32'h1);
        check("t1_q",     32'(q),     32'h00);
        req = 4'b0000;
        tick();                                   // cycle 2
        check("t1_grant_off", 32'(grant),   32'h0);
        check("t1_q_after",   32'(q),       32'h08);
        check("t1_qbar",      32'(qbar),    32'hF7);
        check("t1_cnt",       32'(tog_cnt), 32'h1);
        check("t1_busy_off",  32'(busy),    32'h0);

        // ---------------- round-robin with all requesters ----------------
        do_reset();
        req = 4'b1111;
        sel = 12'b011_010_001_000;                // sel0..3 = 0,1,2,3
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c % 2 == 1)
                check($sformatf("rr_grant_c%0d", c), 32'(grant), 32'(1 << (((c - 1) / 2) % 4)));
            else
                check($sformatf("rr_gap_c%0d", c), 32'(grant), 32'h0);
            if (c == 8) begin
                check("rr_q_c8",   32'(q),       32'h0F);
                check("rr_cnt_c8", 32'(tog_cnt), 32'h4);
            end
        end
        req = 4'b0000;
        tick();                                   // cycle 10: second grant of req0 toggles bit 0
        check("rr_q_c10",   32'(q),       32'h0E);
        check("rr_cnt_c10", 32'(tog_cnt), 32'h5);

        // ---------------- same bit from two requesters ----------------
        do_reset();
        req = 4'b0011;
        set_sel(0, 3'd5);
        set_sel(1, 3'd5);
        tick();
        check("same_g0", 32'(grant), 32'h1);
        req = 4'b0010;
        tick();
        check("same_q1", 32'(q), 32'h20);
        tick();
        check("same_g1", 32'(grant), 32'h2);
        req = 4'b0000;
        tick();
        check("same_q2",   32'(q),       32'h00);
        check("same_cnt2", 32'(tog_cnt), 32'h2);

        // ---------------- freeze in IDLE and during GRANT ----------------
        do_reset();
        freeze = 1'b1;
        req    = 4'b0010;
        set_sel(1, 3'd6);
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("frz_grant_%0d", c), 32'(grant), 32'h0);
        end
        check("frz_q", 32'(q), 32'h00);
        check("frz_busy", 32'(busy), 32'h0);
        freeze = 1'b0;
        tick();
        check("frz_release_grant", 32'(grant), 32'h2);
        freeze = 1'b1;                            // must not cancel the grant in progress
        req    = 4'b0000;
        tick();
        check("frz_grant_done_q", 32'(q),       32'h40);
        check("frz_grant_cnt",    32'(tog_cnt), 32'h1);
        freeze = 1'b0;

        // ---------------- sel captured at grant ----------------
        do_reset();
        req = 4'b0001;
        set_sel(0, 3'd2);
        tick();
        check("cap_grant", 32'(grant), 32'h1);
        set_sel(0, 3'd4);
        req = 4'b0000;
        tick();
        check("cap_q", 32'(q), 32'h04);

        // ---------------- reset during GRANT aborts the toggle ----------------
        do_reset();
        req = 4'b0001;
        set_sel(0, 3'd7);
        tick();
        check("abort_grant", 32'(grant), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0000;
        check("abort_q",     32'(q),       32'h00);
        check("abort_grant0",32'(grant),   32'h0);
        check("abort_cnt",   32'(tog_cnt), 32'h0);
        check("abort_busy",  32'(busy),    32'h0);
        tick();
        check("abort_q_stay", 32'(q), 32'h00);

        // ---------------- saturation over 300 toggles ----------------
        do_reset();
        exp_q = 8'h00;
        req   = 4'b0001;
        for (int n = 0; n < 300; n++) begin
            s = 3'((n * 3 + n / 8) % 8);
            set_sel(0, s);
            tick();                               // GRANT, s captured
            if (n == 0 || n == 299)
                check($sformatf("sat_grant_%0d", n), 32'(grant), 32'h1);
            set_sel(0, ~s);                       // must not affect the captured index
            tick();                               // IDLE, bit s toggled
            exp_q = exp_q ^ (8'h01 << s);
            if (n == 254)
                check("sat_cnt_255", 32'(tog_cnt), 32'd255);
        end
        check("sat_cnt_300", 32'(tog_cnt), 32'd255);
        check("sat_q_parity", 32'(q),      32'(exp_q));
        req = 4'b0000;
        tick();
        tick();
        check("sat_cnt_hold", 32'(tog_cnt), 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
